tcp_rx_msg_noc_if_in_mc: RTL
============================

// Module: tcp_rx_msg_noc_if_in_mc
// PURPOSE
//  Multi-channel successor to the single-port RX message NoC ingress. Takes single-flit app
//  RX-message headers from NUM_IN NoC ports and picks one per cycle with a round-robin arbiter.
//  Buffers decoded headers in a FIFO_DEPTH FIFO. Forks each header to the poller request,
//  RX head-index write and RX free request ports, each branch with its own handshake.
//  A type field selects which branches fire. Sits between the tile NoC routers and the TCP RX poller/state.
// PARAMETERS
//  NUM_IN       2    NoC input channels (1..8)
//  FIFO_DEPTH   4    decoded-header FIFO entries (power of 2, >=2)
//  NOC_DATA_W   512  NoC flit width
//  FLOWID_W     9    flow id width
//  PTR_W        32   payload pointer / length width
//  IDX_W        16   head-index width
//  MLEN_W       16   malloc length width
//  X_W,Y_W,F_W  4,4,4  dst x / y / fbits widths
// PORTS
//  clk              in   1               clock
//  rst_n            in   1               asynchronous active-low reset
//  in_val           in   NUM_IN          per-channel flit valid
//  in_data          in   NUM_IN*NOC_DATA_W  per-channel flit; channel i = [i*NOC_DATA_W +: NOC_DATA_W]
//  in_rdy           out  NUM_IN          per-channel accept
//  poll_val/rdy     out/in 1             poller request handshake
//  poll_flowid      out  FLOWID_W        flow id
//  poll_len         out  PTR_W           requested length
//  poll_dst_x/y/fbits out X_W/Y_W/F_W    reply destination
//  poll_src_chan    out  $clog2(NUM_IN)+1  ingress channel of the message
//  head_wr_val/rdy  out/in 1             head-index write handshake
//  head_wr_addr     out  FLOWID_W        flow id
//  head_wr_data     out  IDX_W           new head index
//  free_val/rdy     out/in 1             free request handshake
//  free_addr        out  PTR_W           buffer address to free
//  free_len         out  MLEN_W          bytes to free
//  err_bad_type     out  1               1-cycle pulse on an accepted flit with type 2'b00
//  msg_cnt          out  32              count of retired messages, wraps
// BEHAVIOUR
//  Flit fields, LSB up: type[1:0], flowid, len(PTR_W), head_idx(IDX_W), free_addr(PTR_W),
//   free_len(MLEN_W), dst_x, dst_y, dst_fbits. Upper bits are ignored.
//  type: 01=POLL only; 10=ADV (head write + free); 11=BOTH; 00=illegal.
//   An illegal flit is accepted and dropped, pulses err_bad_type, and is not enqueued.
//  ADV/BOTH with free_len==0: the free branch is marked done at enqueue, so free_val never asserts.
//  Arbiter: round-robin over in_val. The pointer advances to grant+1 only on an accepted flit.
//   in_rdy[i] = grant[i] & ~fifo_full. At most one in_rdy bit is high per cycle.
//  Enqueue on in_val&in_rdy at cycle t. The entry can reach the outputs at t+1 at the earliest.
//   No combinational in->out path.
//  Dispatch works on the FIFO head entry only. Each branch has a done bit.
//   X_val = head_valid & need_X & ~done_X.
//   done_X sets on X_val & X_rdy.
//   Pop when every needed branch is done or completing this cycle, then clear the done bits.
//  Branches finish independently in any order. Outputs hold stable while val & ~rdy.
//  Full: with FIFO_DEPTH entries present, in_rdy=0. A pop and a push in the same cycle on a full FIFO
//   does not accept the push. Empty: all *_val=0.
//  Pointers are log2(FIFO_DEPTH)+1 bits wide so wrap is handled: full = MSB differ, rest equal.
//  msg_cnt increments on each pop and wraps 2^32-1 -> 0.
//  Reset: all outputs 0; in_rdy=0; FIFO empty; done bits clear; arbiter pointer=0; msg_cnt=0.
//   Reset mid-message drops all buffered and partially dispatched entries.
// TESTING
//  1. POLL flit on ch0, flowid=5, len=0x100, poll_rdy=1 -> poll_val at t+1 with flowid 5, len 0x100,
//     poll_src_chan=0; head_wr_val and free_val stay 0.
//  2. BOTH flit on ch1, head_rdy held 0 for 3 cycles, other rdys 1 -> poll and free retire first;
//     head_wr_val holds with data stable; pop occurs on the cycle head_rdy=1; msg_cnt=1.
//  3. All channels valid continuously, all rdys 1 -> grants cycle 0,1,0,1...; no channel starved.
//  4. All rdys 0, 5 flits offered, FIFO_DEPTH=4 -> 4 accepted, then in_rdy=0;
//     releasing rdys drains in order, and the 5th is accepted after the first pop.
//  5. ADV flit with free_len=0 -> only head_wr_val fires; type=00 flit -> err_bad_type pulse, no outputs.
//  6. rst_n asserted while entries are pending -> outputs drop to 0 asynchronously; FIFO empty after
//     release; next flit dispatches normally.

Source files
------------

// File: rtl/tcp_rx_msg_noc_if_in_mc_if.sv
// Handshake bundle for the multi-channel RX message NoC ingress.
// slave = the ingress block, master = whatever drives the NoC side and sinks the dispatch side.
interface tcp_rx_msg_noc_if_in_mc_if #(
    parameter int NUM_IN     = 2,
    parameter int NOC_DATA_W = 512,
    parameter int FLOWID_W   = 9,
    parameter int PTR_W      = 32,
    parameter int IDX_W      = 16,
    parameter int MLEN_W     = 16,
    parameter int X_W        = 4,
    parameter int Y_W        = 4,
    parameter int F_W        = 4
);
    localparam int CH_W = $clog2(NUM_IN) + 1;

    logic [NUM_IN-1:0]            in_val;
    logic [NUM_IN*NOC_DATA_W-1:0] in_data;
    logic [NUM_IN-1:0]            in_rdy;

    logic                poll_val;
    logic                poll_rdy;
    logic [FLOWID_W-1:0] poll_flowid;
    logic [PTR_W-1:0]    poll_len;
    logic [X_W-1:0]      poll_dst_x;
    logic [Y_W-1:0]      poll_dst_y;
    logic [F_W-1:0]      poll_dst_fbits;
    logic [CH_W-1:0]     poll_src_chan;

    logic                head_wr_val;
    logic                head_wr_rdy;
    logic [FLOWID_W-1:0] head_wr_addr;
    logic [IDX_W-1:0]    head_wr_data;

    logic                free_val;
    logic                free_rdy;
    logic [PTR_W-1:0]    free_addr;
    logic [MLEN_W-1:0]   free_len;

    logic                err_bad_type;
    logic [31:0]         msg_cnt;

    modport slave (
        input  in_val, in_data, poll_rdy, head_wr_rdy, free_rdy,
        output in_rdy,
        output poll_val, poll_flowid, poll_len, poll_dst_x, poll_dst_y, poll_dst_fbits, poll_src_chan,
        output head_wr_val, head_wr_addr, head_wr_data,
        output free_val, free_addr, free_len,
        output err_bad_type, msg_cnt
    );

    modport master (
        output in_val, in_data, poll_rdy, head_wr_rdy, free_rdy,
        input  in_rdy,
        input  poll_val, poll_flowid, poll_len, poll_dst_x, poll_dst_y, poll_dst_fbits, poll_src_chan,
        input  head_wr_val, head_wr_addr, head_wr_data,
        input  free_val, free_addr, free_len,
        input  err_bad_type, msg_cnt
    );
endinterface

// File: rtl/tcp_rx_msg_noc_if_in_mc.sv
// Multi-channel RX message NoC ingress: round-robin pick of one header flit per cycle,
// decoded-header FIFO, and a three-way fork (poll / head write / free) off the FIFO head
// where each branch completes on its own handshake.
module tcp_rx_msg_noc_if_in_mc #(
    parameter int NUM_IN     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int NOC_DATA_W = 512,
    parameter int FLOWID_W   = 9,
    parameter int PTR_W      = 32,
    parameter int IDX_W      = 16,
    parameter int MLEN_W     = 16,
    parameter int X_W        = 4,
    parameter int Y_W        = 4,
    parameter int F_W        = 4
) (
    input logic clk,
    input logic rst_n,
    tcp_rx_msg_noc_if_in_mc_if.slave bus
);
    localparam int CH_W      = $clog2(NUM_IN) + 1;
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int OFF_FLOW  = 2;
    localparam int OFF_LEN   = OFF_FLOW + FLOWID_W;
    localparam int OFF_HIDX  = OFF_LEN + PTR_W;
    localparam int OFF_FADDR = OFF_HIDX + IDX_W;
    localparam int OFF_FLEN  = OFF_FADDR + PTR_W;
    localparam int OFF_X     = OFF_FLEN + MLEN_W;
    localparam int OFF_Y     = OFF_X + X_W;
    localparam int OFF_F     = OFF_Y + Y_W;
    localparam int FLIT_W    = OFF_F + F_W;

    typedef struct packed {
        logic                need_poll;
        logic                need_head;
        logic                need_free;
        logic [FLOWID_W-1:0] flowid;
        logic [PTR_W-1:0]    len;
        logic [IDX_W-1:0]    head_idx;
        logic [PTR_W-1:0]    free_addr;
        logic [MLEN_W-1:0]   free_len;
        logic [X_W-1:0]      dst_x;
        logic [Y_W-1:0]      dst_y;
        logic [F_W-1:0]      dst_f;
        logic [CH_W-1:0]     chan;
    } entry_t;

    logic [CH_W-1:0]   rr_q, rr_d;
    logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
    logic              done_poll_q, done_poll_d;
    logic              done_head_q, done_head_d;
    logic              done_free_q, done_free_d;
    logic              err_q, err_d;
    logic [31:0]       msg_cnt_q, msg_cnt_d;
    entry_t            mem_q [FIFO_DEPTH];
    entry_t            entry_d;
    entry_t            head;

    logic [2*NUM_IN-1:0] val_dbl;
    logic [NUM_IN-1:0]   val_rot;
    logic [NUM_IN-1:0]   in_rdy_c;
    logic [CH_W:0]       grant_sum;
    logic [CH_W-1:0]     grant_idx;
    logic                grant_any;
    logic [FLIT_W-1:0]   flit;
    logic                full, empty, head_valid, accept, push, pop;
    logic                poll_val, head_val, free_val;
    logic                poll_fire, head_fire, free_fire;

    // Wrap-aware pointers: equal means empty, MSB-only difference means full.
    assign empty      = (wr_q == rd_q);
    assign full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head_valid = ~empty;
    assign head       = mem_q[rd_q[AW-1:0]];

    // Round-robin search: rotate valids so bit 0 is the pointer, take the first set bit.
    always_comb begin
        val_dbl   = {bus.in_val, bus.in_val};
        val_rot   = NUM_IN'(val_dbl >> rr_q);
        grant_any = 1'b0;
        grant_sum = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (!grant_any && val_rot[k]) begin
                grant_any = 1'b1;
                grant_sum = {1'b0, rr_q} + (CH_W+1)'(k);
            end
        end
        if (grant_sum >= (CH_W+1)'(NUM_IN)) begin
            grant_sum = grant_sum - (CH_W+1)'(NUM_IN);
        end
        grant_idx = grant_sum[CH_W-1:0];
    end

    // Accept the granted flit when the FIFO has room; decode it and advance the pointer.
    always_comb begin
        flit     = '0;
        in_rdy_c = '0;
        accept   = grant_any & ~full & rst_n;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_idx == CH_W'(i)) begin
                flit        = bus.in_data[i*NOC_DATA_W +: FLIT_W];
                in_rdy_c[i] = accept;
            end
        end
        push  = accept & (flit[1:0] != 2'b00);
        err_d = accept & (flit[1:0] == 2'b00);

        entry_d.need_poll = flit[0];
        entry_d.need_head = flit[1];
        // A zero-length free has nothing to release, so it counts as done from the start.
        entry_d.need_free = flit[1] & (flit[OFF_FLEN +: MLEN_W] != '0);
        entry_d.flowid    = flit[OFF_FLOW +: FLOWID_W];
        entry_d.len       = flit[OFF_LEN +: PTR_W];
        entry_d.head_idx  = flit[OFF_HIDX +: IDX_W];
        entry_d.free_addr = flit[OFF_FADDR +: PTR_W];
        entry_d.free_len  = flit[OFF_FLEN +: MLEN_W];
        entry_d.dst_x     = flit[OFF_X +: X_W];
        entry_d.dst_y     = flit[OFF_Y +: Y_W];
        entry_d.dst_f     = flit[OFF_F +: F_W];
        entry_d.chan      = grant_idx;

        rr_d = rr_q;
        if (accept) begin
            rr_d = (grant_idx == CH_W'(NUM_IN - 1)) ? '0 : grant_idx + CH_W'(1);
        end
    end

    // Fork the head entry; pop once every needed branch is done or finishing now.
    always_comb begin
        poll_val  = head_valid & head.need_poll & ~done_poll_q;
        head_val  = head_valid & head.need_head & ~done_head_q;
        free_val  = head_valid & head.need_free & ~done_free_q;
        poll_fire = poll_val & bus.poll_rdy;
        head_fire = head_val & bus.head_wr_rdy;
        free_fire = free_val & bus.free_rdy;
        pop = head_valid
            & (~head.need_poll | done_poll_q | poll_fire)
            & (~head.need_head | done_head_q | head_fire)
            & (~head.need_free | done_free_q | free_fire);
        done_poll_d = pop ? 1'b0 : (done_poll_q | poll_fire);
        done_head_d = pop ? 1'b0 : (done_head_q | head_fire);
        done_free_d = pop ? 1'b0 : (done_free_q | free_fire);
        wr_d        = wr_q + (AW+1)'(push);
        rd_d        = rd_q + (AW+1)'(pop);
        msg_cnt_d   = msg_cnt_q + 32'(pop);
    end

    // Control state; a reset drops every buffered and partially dispatched entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q        <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            done_poll_q <= 1'b0;
            done_head_q <= 1'b0;
            done_free_q <= 1'b0;
            err_q       <= 1'b0;
            msg_cnt_q   <= '0;
        end else begin
            rr_q        <= rr_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            done_poll_q <= done_poll_d;
            done_head_q <= done_head_d;
            done_free_q <= done_free_d;
            err_q       <= err_d;
            msg_cnt_q   <= msg_cnt_d;
        end
    end

    // Header storage; validity is tracked by the pointers, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]] <= entry_d;
        end
    end

    assign bus.in_rdy         = in_rdy_c;
    assign bus.poll_val       = poll_val;
    assign bus.poll_flowid    = head_valid ? head.flowid : '0;
    assign bus.poll_len       = head_valid ? head.len : '0;
    assign bus.poll_dst_x     = head_valid ? head.dst_x : '0;
    assign bus.poll_dst_y     = head_valid ? head.dst_y : '0;
    assign bus.poll_dst_fbits = head_valid ? head.dst_f : '0;
    assign bus.poll_src_chan  = head_valid ? head.chan : '0;
    assign bus.head_wr_val    = head_val;
    assign bus.head_wr_addr   = head_valid ? head.flowid : '0;
    assign bus.head_wr_data   = head_valid ? head.head_idx : '0;
    assign bus.free_val       = free_val;
    assign bus.free_addr      = head_valid ? head.free_addr : '0;
    assign bus.free_len       = head_valid ? head.free_len : '0;
    assign bus.err_bad_type   = err_q;
    assign bus.msg_cnt        = msg_cnt_q;
endmodule
